// File: rtl/pfb_pkg.sv
// Shared constants for the PFB datapath: default geometry, widths and scaling.
package pfb_pkg;

  localparam int PFB_NUM_TAPS     = 8;
  localparam int PFB_NUM_CHANNELS = 64;
  localparam int PFB_SAMPLE_W     = 16;
  localparam int PFB_PROD_W       = 32;
  localparam int PFB_OUT_W        = 16;
  localparam int PFB_SHIFT        = 15;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v > 1) ? v : 1;
  endfunction

endpackage

// File: rtl/pfb_tap_accumulator_if.sv
// Product stream in, per-channel result stream out, plus the sticky alignment flag.
interface pfb_tap_accumulator_if import pfb_pkg::*; #(
  parameter int IN_WIDTH  = PFB_PROD_W,
  parameter int OUT_WIDTH = PFB_OUT_W,
  parameter int CH_W      = 6
);
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_last;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [CH_W-1:0]             out_chan;
  logic                        out_last;
  logic                        out_sat;
  logic                        err_sync;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_chan, out_last, out_sat, err_sync
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_chan, out_last, out_sat, err_sync
  );
endinterface

// File: rtl/pfb_round_sat.sv
// Round half toward +inf, arithmetic shift right, then clip into OUT_W signed bits.
module pfb_round_sat import pfb_pkg::*; #(
  parameter int IN_W  = 35,
  parameter int OUT_W = PFB_OUT_W,
  parameter int SHIFT = PFB_SHIFT
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);
  // One extra bit so adding the rounding constant can never wrap.
  localparam int RW = IN_W + 1;
  localparam logic [RW-1:0] RND = (RW'(1) << SHIFT) >> 1;
  localparam logic signed [RW-1:0] HI = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] LO = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [RW-1:0] r;
  logic signed [RW-1:0] q;

  always_comb begin
    r    = {din[IN_W-1], din} + RND;
    q    = r >>> SHIFT;
    sat  = 1'b0;
    dout = q[OUT_W-1:0];
    if (q > HI) begin
      sat  = 1'b1;
      dout = HI[OUT_W-1:0];
    end else if (q < LO) begin
      sat  = 1'b1;
      dout = LO[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/pfb_tap_accumulator.sv
// Sums NUM_TAPS products per channel, scales each channel sum to OUT_WIDTH and
// streams it out with its channel index; in_last is checked against the counters.
module pfb_tap_accumulator import pfb_pkg::*; #(
  parameter int NUM_TAPS     = PFB_NUM_TAPS,
  parameter int NUM_CHANNELS = PFB_NUM_CHANNELS,
  parameter int IN_WIDTH     = PFB_PROD_W,
  parameter int OUT_WIDTH    = PFB_OUT_W,
  parameter int SHIFT        = PFB_SHIFT
) (
  input logic                  ap_clk,
  input logic                  ap_rst,
  pfb_tap_accumulator_if.slave s
);
  localparam int ACC_WIDTH = IN_WIDTH + clog2(NUM_TAPS);
  localparam int CH_W      = max1(clog2(NUM_CHANNELS));
  localparam int TAP_W     = max1(clog2(NUM_TAPS));
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);

  logic [TAP_W-1:0]            tap_cnt_q, tap_cnt_d;
  logic [CH_W-1:0]             chan_cnt_q, chan_cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]             out_chan_q, out_chan_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic                        out_sat_q, out_sat_d;
  logic                        err_sync_q, err_sync_d;

  logic                        accept, last_tap, last_chan, aligned;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [OUT_WIDTH-1:0] rs_data;
  logic                        rs_sat;

  assign s.in_ready = !out_valid_q || s.out_ready;
  assign accept     = s.in_valid && s.in_ready;
  assign last_tap   = (tap_cnt_q == TAP_LAST);
  assign last_chan  = (chan_cnt_q == CH_LAST);
  assign aligned    = last_tap && last_chan;

  // Tap 0 restarts the sum, so acc never needs clearing between channels.
  assign sum = ((tap_cnt_q == '0) ? '0 : acc_q)
             + {{(ACC_WIDTH-IN_WIDTH){s.in_data[IN_WIDTH-1]}}, s.in_data};

  pfb_round_sat #(
    .IN_W  (ACC_WIDTH),
    .OUT_W (OUT_WIDTH),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .din  (sum),
    .dout (rs_data),
    .sat  (rs_sat)
  );

  always_comb begin
    tap_cnt_d   = tap_cnt_q;
    chan_cnt_d  = chan_cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;
    err_sync_d  = err_sync_q;

    if (out_valid_q && s.out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (s.in_last != aligned) err_sync_d = 1'b1;
      // Early in_last: drop the partial channel and resynchronise to frame start.
      if (s.in_last && !aligned) begin
        tap_cnt_d  = '0;
        chan_cnt_d = '0;
      end else begin
        acc_d = sum;
        if (last_tap) begin
          tap_cnt_d   = '0;
          chan_cnt_d  = last_chan ? '0 : chan_cnt_q + CH_W'(1);
          out_valid_d = 1'b1;
          out_data_d  = rs_data;
          out_chan_d  = chan_cnt_q;
          out_last_d  = last_chan;
          out_sat_d   = rs_sat;
        end else begin
          tap_cnt_d = tap_cnt_q + TAP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      tap_cnt_q   <= '0;
      chan_cnt_q  <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      err_sync_q  <= 1'b0;
    end else begin
      tap_cnt_q   <= tap_cnt_d;
      chan_cnt_q  <= chan_cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
      err_sync_q  <= err_sync_d;
    end
  end

  assign s.out_data  = out_data_q;
  assign s.out_chan  = out_chan_q;
  assign s.out_valid = out_valid_q;
  assign s.out_last  = out_last_q;
  assign s.out_sat   = out_sat_q;
  assign s.err_sync  = err_sync_q;
endmodule

// File: tb/tb_pfb_tap_accumulator.sv
// Randomised frames against a per-channel arithmetic model; a monitor pops a
// scoreboard on every output handshake and checks held outputs under backpressure.
module tb_pfb_tap_accumulator;
  import pfb_pkg::*;

  localparam int NT = 8;
  localparam int NC = 64;
  localparam int SH = 15;
  localparam int OW = 16;
  localparam int CW = 6;

  logic ap_clk = 1'b0;
  logic ap_rst;
  always #5 ap_clk = ~ap_clk;

  pfb_tap_accumulator_if #(.IN_WIDTH(32), .OUT_WIDTH(OW), .CH_W(CW)) bus ();

  pfb_tap_accumulator #(
    .NUM_TAPS(NT), .NUM_CHANNELS(NC), .IN_WIDTH(32), .OUT_WIDTH(OW), .SHIFT(SH)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .s      (bus)
  );

  typedef struct {
    int data;
    int chan;
    bit last;
    bit sat;
  } exp_t;

  exp_t sb[$];
  int   fr[NC][NT];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low

  task automatic check(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact channel sum, floor((sum + 2^(SH-1)) / 2^SH), then clip.
  function automatic exp_t model(input int c);
    longint sum, q;
    exp_t   e;
    sum = 0;
    for (int t = 0; t < NT; t++) sum += longint'(fr[c][t]);
    q = (sum + (longint'(1) << (SH - 1))) >>> SH;
    e.sat = 1'b0;
    if (q > 32767) begin
      q = 32767;  e.sat = 1'b1;
    end else if (q < -32768) begin
      q = -32768; e.sat = 1'b1;
    end
    e.data = int'(q);
    e.chan = c;
    e.last = (c == NC - 1);
    return e;
  endfunction

  always @(posedge ap_clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor
  bit              hold_pend = 1'b0;
  logic [OW-1:0]   h_data;
  logic [CW-1:0]   h_chan;
  logic            h_last, h_sat;
  exp_t            me;

  always @(negedge ap_clk) begin
    if (ap_rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        check(bus.out_valid === 1'b1 && bus.out_data === h_data && bus.out_chan === h_chan &&
              bus.out_last === h_last && bus.out_sat === h_sat,
              "hold_stable", longint'($signed(bus.out_data)), longint'($signed(h_data)));
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_output_chan", longint'(bus.out_chan), -1);
        end else begin
          me = sb.pop_front();
          check(int'($signed(bus.out_data)) == me.data, "out_data",
                longint'($signed(bus.out_data)), me.data);
          check(int'(bus.out_chan) == me.chan, "out_chan", longint'(bus.out_chan), me.chan);
          check(bus.out_last == me.last && bus.out_sat == me.sat, "last_sat",
                {bus.out_last, bus.out_sat}, {me.last, me.sat});
        end
      end
      hold_pend = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      h_data = bus.out_data;
      h_chan = bus.out_chan;
      h_last = bus.out_last;
      h_sat  = bus.out_sat;
    end
  end

  task automatic summary_fatal(input string why);
    $display("FAIL %s: got timeout expected progress", why);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "stopped");
  endtask

  task automatic send_beat(input int d, input bit l);
    int g;
    @(negedge ap_clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    g = 0;
    while (bus.in_ready !== 1'b1) begin
      @(negedge ap_clk); #1;
      g++;
      if (g > 2000) summary_fatal("in_ready_wait");
    end
  endtask

  task automatic idle();
    @(negedge ap_clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Sends beats 0..nbeats-1 in frame order. mark_beat>=0 raises in_last there and stops.
  task automatic send_frame(input int nbeats, input int mark_beat, input bit drop_last, input bit push);
    int c, t;
    bit l;
    for (int b = 0; b < nbeats; b++) begin
      c = b / NT;
      t = b % NT;
      l = (b == NC * NT - 1) && !drop_last;
      if (b == mark_beat) l = 1'b1;
      send_beat(fr[c][t], l);
      if (b == mark_beat) break;
      if (t == NT - 1 && push) sb.push_back(model(c));
    end
    idle();
  endtask

  task automatic gen_rand();
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < NT; t++)
        case ($urandom_range(0, 3))
          0:       fr[c][t] = int'($urandom_range(0, 131071)) - 65536;
          1:       fr[c][t] = int'($urandom) >>> 6;
          2:       fr[c][t] = int'($urandom);
          default: fr[c][t] = int'($urandom) >>> 2;
        endcase
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || bus.out_valid === 1'b1) && g < 3000) begin
      @(negedge ap_clk); #1;
      g++;
    end
    check(sb.size() == 0, "drain_pending", sb.size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge ap_clk); #1;
    ap_rst       = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge ap_clk); #1;
    ap_rst = 1'b0;
    sb.delete();
  endtask

  task automatic check_idle_outputs(input string nm);
    check(bus.out_valid === 1'b0, {nm, "_valid"}, bus.out_valid, 0);
    check(bus.out_data === '0 && bus.out_chan === '0, {nm, "_data_chan"},
          longint'($signed(bus.out_data)), 0);
    check(bus.out_last === 1'b0 && bus.out_sat === 1'b0, {nm, "_last_sat"},
          {bus.out_last, bus.out_sat}, 0);
    check(bus.err_sync === 1'b0, {nm, "_err_sync"}, bus.err_sync, 0);
    check(bus.in_ready === 1'b1, {nm, "_in_ready"}, bus.in_ready, 1);
  endtask

  task automatic stall_thread();
    int g;
    g = 0;
    @(negedge ap_clk); #1;
    while (bus.out_valid !== 1'b1 && g < 2000) begin
      @(negedge ap_clk); #1;
      g++;
    end
    check(bus.out_valid === 1'b1, "stall_first_result", bus.out_valid, 1);
    repeat (20) begin
      @(negedge ap_clk); #1;
      check(bus.in_ready === 1'b0, "stall_in_ready", bus.in_ready, 0);
    end
    rdy_mode = 0;
  endtask

  initial begin
    #900000;
    summary_fatal("watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 0;
    bus.in_last  = 1'b0;
    ap_rst       = 1'b1;
    repeat (3) @(negedge ap_clk);
    #1 ap_rst = 1'b0;
    check_idle_outputs("reset");

    // Constant 2^15 products: each channel is 8.
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < NT; t++) fr[c][t] = 32'h0000_8000;
    send_frame(NC * NT, -1, 1'b0, 1'b1);
    drain();
    check(bus.err_sync === 1'b0, "const_err_sync", bus.err_sync, 0);

    // Rounding boundaries and saturation at both rails.
    gen_rand();
    for (int t = 0; t < NT; t++) begin
      fr[0][t] = (t == 0) ? 32'h0000_4000 : 0;
      fr[1][t] = (t == 0) ? 32'h0000_3FFF : 0;
      fr[2][t] = (t == 0) ? -32'sh4000 : 0;
      fr[3][t] = (t == 0) ? -32'sh4001 : 0;
      fr[4][t] = 32'h4000_0000;
      fr[5][t] = 32'h8000_0000;
    end
    send_frame(NC * NT, -1, 1'b0, 1'b1);
    drain();

    // Held result under 20 cycles of backpressure.
    gen_rand();
    rdy_mode = 2;
    fork
      send_frame(NC * NT, -1, 1'b0, 1'b1);
      stall_thread();
    join
    drain();

    // Random downstream readiness over three frames.
    rdy_mode = 1;
    repeat (3) begin
      gen_rand();
      send_frame(NC * NT, -1, 1'b0, 1'b1);
    end
    drain();
    rdy_mode = 0;
    check(bus.err_sync === 1'b0, "random_err_sync", bus.err_sync, 0);

    // Early in_last on tap 3 of channel 5, then a clean frame.
    gen_rand();
    send_frame(NC * NT, 5 * NT + 3, 1'b0, 1'b1);
    check(bus.err_sync === 1'b1, "early_last_err", bus.err_sync, 1);
    gen_rand();
    send_frame(NC * NT, -1, 1'b0, 1'b1);
    drain();
    check(bus.err_sync === 1'b1, "err_sticky", bus.err_sync, 1);

    // Missing in_last on the frame's final beat: flag only, counters wrap.
    pulse_reset();
    check(bus.err_sync === 1'b0, "err_cleared", bus.err_sync, 0);
    gen_rand();
    send_frame(NC * NT, -1, 1'b1, 1'b1);
    drain();
    check(bus.err_sync === 1'b1, "missing_last_err", bus.err_sync, 1);
    gen_rand();
    send_frame(NC * NT, -1, 1'b0, 1'b1);
    drain();

    // Reset while a result is held.
    rdy_mode = 2;
    gen_rand();
    send_frame(NT, -1, 1'b0, 1'b0);
    @(negedge ap_clk); #1;
    check(bus.out_valid === 1'b1, "held_before_reset", bus.out_valid, 1);
    pulse_reset();
    check_idle_outputs("held_reset");
    rdy_mode = 0;

    // Reset mid-channel, then a full frame from channel 0.
    gen_rand();
    send_frame(NT + 3, -1, 1'b0, 1'b1);
    drain();
    pulse_reset();
    check_idle_outputs("midchan_reset");
    gen_rand();
    send_frame(NC * NT, -1, 1'b0, 1'b1);
    drain();
    check(bus.err_sync === 1'b0, "final_err_sync", bus.err_sync, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
